branch_resolve_unit: RTL

Tracks in-flight conditional branches between fetch and execute and resolves each against its actual outcome. Sits directly downstream of the 1-bit direction predictor (`counterOne`): it queues the predictor's PREDICTION at fetch, and at resolution produces the OUTCOME/MISS pair that trains the counter. It also produces the pipeline FLUSH and the REDIRECT_PC.

---
 rtl/branch_resolve_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-flight branch queue and resolver (optional BRU_STATS_EN counters)
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     CLOCK,
  input  logic                     INIT,
  input  logic                     PRED_VALID,
  input  logic                     PREDICTION,
  input  logic [PC_W-1:0]          PRED_PC,
  input  logic [PC_W-1:0]          PRED_TARGET,
  input  logic                     RES_VALID,
  input  logic                     RES_TAKEN,
  input  logic [PC_W-1:0]          RES_TARGET,
  output logic                     UPD_VALID,
  output logic                     OUTCOME,
  output logic                     MISS,
  output logic                     FLUSH,
  output logic [PC_W-1:0]          REDIRECT_PC,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]              BR_TOTAL,
  output logic [31:0]              BR_MISSES
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic            q_pred [DEPTH];
  logic [PC_W-1:0] q_pc   [DEPTH];
  logic [PC_W-1:0] q_tgt  [DEPTH];

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [0:0]      state;

  logic            pop;
  logic            miss_now;
  logic            push;
  logic [PC_W-1:0] redirect_now;
  logic [CW-1:0]   count_next;

  always_comb begin
    pop          = RES_VALID && (count != '0);
    miss_now     = pop && ((q_pred[head] != RES_TAKEN) ||
                           (RES_TAKEN && (q_tgt[head] != RES_TARGET)));
    redirect_now = RES_TAKEN ? RES_TARGET : (q_pc[head] + PC_W'(4));
    // Wrong-path fetches (miss cycle and the flush cycle after) never enter the queue
    push         = PRED_VALID && (state == S_RUN) && !miss_now &&
                   ((count != DEPTH_C) || pop);
    count_next   = count;
    if (miss_now)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      FULL        <= 1'b0;
      state       <= S_RUN;
      UPD_VALID   <= 1'b0;
      OUTCOME     <= 1'b0;
      MISS        <= 1'b0;
      REDIRECT_PC <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pred[i] <= 1'b0;
        q_pc[i]   <= '0;
        q_tgt[i]  <= '0;
      end
    end else begin
      if (push) begin
        q_pred[tail] <= PREDICTION;
        q_pc[tail]   <= PRED_PC;
        q_tgt[tail]  <= PRED_TARGET;
      end
      // A miss collapses the queue to empty just past the resolved entry
      if (miss_now) begin
        head <= head + AW'(1);
        tail <= head + AW'(1);
      end else begin
        if (pop)
          head <= head + AW'(1);
        if (push)
          tail <= tail + AW'(1);
      end
      count     <= count_next;
      FULL      <= (count_next == DEPTH_C);
      state     <= miss_now ? S_FLUSH : S_RUN;
      UPD_VALID <= pop;
      OUTCOME   <= pop && RES_TAKEN;
      MISS      <= miss_now;
      if (miss_now)
        REDIRECT_PC <= redirect_now;
    end
  end

  assign FLUSH = (state == S_FLUSH);
  assign COUNT = count;

`ifdef BRU_STATS_EN
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      BR_TOTAL  <= '0;
      BR_MISSES <= '0;
    end else if (UPD_VALID) begin
      BR_TOTAL <= BR_TOTAL + 32'd1;
      if (MISS)
        BR_MISSES <= BR_MISSES + 32'd1;
    end
  end
`endif

endmodule
